// File: rtl/fp_add_normalize.sv
// ---------------------------------------------------------------------------
// fp_add_normalize
// Add / normalize / round stage of the binary32 adder. Takes the aligned,
// swapped mantissa pair (great >= small), the common exponent and result
// sign. Produces a packed IEEE-754 binary32 result using round-to-nearest-even.
// Normalization runs one left shift per cycle under a small FSM.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid & ready are both high. A producer holding valid keeps its data
// stable until that edge. in_ready is a pure decode of the state register,
// so there is no combinational path from out_ready to in_ready.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  input handshake (in_ready high only in IDLE)
//   sign, exp          result sign and common exponent (denormals: exp=1)
//   mantis_great/small 28-bit aligned mantissas {0, hidden, frac[22:0], g, r, s}
//   eff_sub            1 = subtract small from great, 0 = add
//   special_in         bypass: special_result is the answer
//   special_result     packed result used for the bypass
//   out_valid/out_ready output handshake
//   result, overflow   packed result and carried-to-infinity flag
//   dbg_state          current FSM state encoding
// ---------------------------------------------------------------------------
module fp_add_normalize (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign,
  input  logic [7:0]  exp,
  input  logic [27:0] mantis_great,
  input  logic [27:0] mantis_small,
  input  logic        eff_sub,
  input  logic        special_in,
  input  logic [31:0] special_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADD   = 3'd1,
    S_NORM  = 3'd2,
    S_ROUND = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_sign;
  logic [7:0]  r_exp;
  logic [27:0] r_sum;
  logic [27:0] r_small;
  logic        r_eff_sub;
  logic        r_ovf;
  logic [31:0] r_result;
  logic        r_overflow;

  logic [27:0] w_sum;
  logic        w_norm_shift;
  logic        w_inc;
  logic [24:0] w_rnd;
  logic [23:0] w_mant;
  logic [8:0]  w_exp_r;
  logic        w_rovf;
  logic [7:0]  w_exp_field;
  logic [31:0] w_packed;

  // Operands are < 2^27 each, so the 28-bit sum cannot wrap; great >= small
  // keeps the difference non-negative.
  assign w_sum = r_eff_sub ? (r_sum - r_small) : (r_sum + r_small);

  // Stop shifting once the hidden bit is set, the value is zero, or the
  // exponent has reached the denormal floor.
  assign w_norm_shift = (r_sum != 28'd0) && !r_sum[26] && (r_exp > 8'd1);

  // Round to nearest even on the bits below the LSB (sum[3]).
  assign w_inc   = r_sum[2] & (r_sum[1] | r_sum[0] | r_sum[3]);
  assign w_rnd   = r_sum[27:3] + {24'd0, w_inc};
  // A rounding carry into bit 27 renormalizes by one position right.
  assign w_mant  = w_rnd[24] ? w_rnd[24:1] : w_rnd[23:0];
  assign w_exp_r = {1'b0, r_exp} + {8'd0, w_rnd[24]};
  assign w_rovf  = r_ovf | (w_exp_r >= 9'd255);
  // Without the hidden bit the value is denormal; a denormal that rounds up
  // into the hidden bit naturally picks up the exponent 1 it was carried at.
  assign w_exp_field = w_mant[23] ? w_exp_r[7:0] : 8'd0;

  always_comb begin
    w_packed = {r_sign, w_exp_field, w_mant[22:0]};
    if (w_rovf) begin
      w_packed = {r_sign, 8'hFF, 23'd0};
    end else if (r_sum == 28'd0) begin
      // Exact cancellation always yields +0.
      w_packed = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = special_in ? S_OUT : S_ADD;
        end
      end
      S_ADD:   w_next = S_NORM;
      S_NORM: begin
        if (!w_norm_shift) begin
          w_next = S_ROUND;
        end
      end
      S_ROUND: w_next = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign     <= 1'b0;
      r_exp      <= 8'd0;
      r_sum      <= 28'd0;
      r_small    <= 28'd0;
      r_eff_sub  <= 1'b0;
      r_ovf      <= 1'b0;
      r_result   <= 32'd0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign    <= sign;
            r_exp     <= exp;
            r_sum     <= mantis_great;
            r_small   <= mantis_small;
            r_eff_sub <= eff_sub;
            r_ovf     <= 1'b0;
            if (special_in) begin
              r_result   <= special_result;
              r_overflow <= 1'b0;
            end
          end
        end
        S_ADD: begin
          if (w_sum[27]) begin
            // Shift right once, folding the dropped bit into sticky.
            r_sum <= {1'b0, w_sum[27:2], w_sum[1] | w_sum[0]};
            r_exp <= r_exp + 8'd1;
            if (r_exp == 8'd254) begin
              r_ovf <= 1'b1;
            end
          end else begin
            r_sum <= w_sum;
          end
        end
        S_NORM: begin
          if (w_norm_shift) begin
            r_sum <= r_sum << 1;
            r_exp <= r_exp - 8'd1;
          end
        end
        S_ROUND: begin
          r_result   <= w_packed;
          r_overflow <= w_rovf;
        end
        default: ;
      endcase
    end
  end

  assign result    = r_result;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fp_add_normalize.sv
module tb_fp_add_normalize;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign;
  logic [7:0]  op_exp;
  logic [27:0] mantis_great;
  logic [27:0] mantis_small;
  logic        eff_sub;
  logic        special_in;
  logic [31:0] special_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  logic [31:0] exp_q[$];
  logic        exp_ovf_q[$];
  int          exp_lat_q[$];

  fp_add_normalize dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sign(sign), .exp(op_exp), .mantis_great(mantis_great),
    .mantis_small(mantis_small), .eff_sub(eff_sub), .special_in(special_in),
    .special_result(special_result), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference model: straightforward integer arithmetic.
  function automatic void model(input logic sg, input logic [7:0] e,
                                input logic [27:0] g, input logic [27:0] s,
                                input logic sub, output logic [31:0] res,
                                output logic ovf, output int k);
    longint m, keep, rem;
    int ex;
    logic [7:0] ef;
    m  = sub ? (longint'(g) - longint'(s)) : (longint'(g) + longint'(s));
    ex = e;
    if (m >= (64'd1 << 27)) begin
      m = (m >> 1) | (m & 1);
      ex++;
    end
    k = 0;
    while (m != 0 && m < (64'd1 << 26) && ex > 1) begin
      m = m << 1;
      ex--;
      k++;
    end
    keep = m >> 3;
    rem  = m & 7;
    if (rem > 4 || (rem == 4 && keep[0])) keep++;
    if (keep >= (64'd1 << 24)) begin
      keep = keep >> 1;
      ex++;
    end
    ovf = 1'b0;
    if (ex >= 255) begin
      res = {sg, 8'hFF, 23'd0};
      ovf = 1'b1;
    end else if (m == 0) begin
      res = 32'd0;
    end else begin
      ef  = (keep >= (64'd1 << 23)) ? ex[7:0] : 8'd0;
      res = {sg, ef, keep[22:0]};
    end
  endfunction

  // Driver: called at a negedge, returns at the negedge after acceptance.
  task automatic send(input logic sg, input logic [7:0] e, input logic [27:0] g,
                      input logic [27:0] s, input logic sub, input logic sp,
                      input logic [31:0] sr, input logic [31:0] er,
                      input logic eo, input int el);
    int n;
    sign = sg; op_exp = e; mantis_great = g; mantis_small = s;
    eff_sub = sub; special_in = sp; special_result = sr; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(er);
    exp_ovf_q.push_back(eo);
    exp_lat_q.push_back(el);
    @(negedge clk);
    acc_cyc = cyc;
    in_valid = 1'b0;
    // Inputs are only sampled at acceptance; scramble them afterwards.
    sign = 1'($urandom); op_exp = 8'($urandom); mantis_great = 28'($urandom);
    mantis_small = 28'($urandom); eff_sub = 1'($urandom);
    special_in = 1'($urandom); special_result = $urandom;
    check("in_ready_busy", {31'd0, in_ready}, 32'd0);
  endtask

  // Scoreboard side: wait for out_valid, compare, optionally stall, handshake.
  task automatic recv(input int hold);
    int n;
    logic [31:0] er;
    logic eo;
    int el;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd0, 32'd1);
      return;
    end
    er = exp_q.pop_front();
    eo = exp_ovf_q.pop_front();
    el = exp_lat_q.pop_front();
    if (!out_valid) begin
      check("output_timeout", 32'd0, 32'd1);
      return;
    end
    check("result", result, er);
    check("overflow", {31'd0, overflow}, {31'd0, eo});
    check("latency", cyc - acc_cyc + 1, el);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("stall_result", result, er);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_valid", {31'd0, out_valid}, 32'd0);
    check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] mres;
    logic        movf;
    int          mk;
    logic [27:0] g, s;
    logic [7:0]  e;
    logic        sub, sg;
    logic        seen;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sign = 1'b0; op_exp = 8'd0; mantis_great = 28'd0; mantis_small = 28'd0;
    eff_sub = 1'b0; special_in = 1'b0; special_result = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1.0 + 1.0
    send(1'b0, 8'd127, 28'h4000000, 28'h4000000, 1'b0, 1'b0, 32'd0, 32'h40000000, 1'b0, 4);
    recv(0);
    // 1.0 - 0.75: two normalization shifts
    send(1'b0, 8'd127, 28'h4000000, 28'h3000000, 1'b1, 1'b0, 32'd0, 32'h3E800000, 1'b0, 6);
    recv(0);
    // x - x with negative sign gives +0
    send(1'b1, 8'd127, 28'h5A00000, 28'h5A00000, 1'b1, 1'b0, 32'd0, 32'h00000000, 1'b0, 4);
    recv(0);
    // Carry out of the largest exponent
    send(1'b0, 8'd254, 28'h7FFFFF8, 28'h7FFFFF8, 1'b0, 1'b0, 32'd0, 32'h7F800000, 1'b1, 4);
    recv(0);
    // Ties: even LSB stays, odd LSB rounds up
    send(1'b0, 8'd127, 28'h4000004, 28'h0, 1'b0, 1'b0, 32'd0, 32'h3F800000, 1'b0, 4);
    recv(0);
    send(1'b0, 8'd127, 28'h400000C, 28'h0, 1'b0, 1'b0, 32'd0, 32'h3F800002, 1'b0, 4);
    recv(0);
    // Denormal rounding up into the hidden bit gets exponent field 1
    send(1'b0, 8'd1, 28'h3FFFFFC, 28'h0, 1'b0, 1'b0, 32'd0, 32'h00800000, 1'b0, 4);
    recv(0);
    // Special bypass
    send(1'b0, 8'd3, 28'h123, 28'h45, 1'b1, 1'b1, 32'h7FC00000, 32'h7FC00000, 1'b0, 1);
    recv(0);

    // Output stall with a competing request held on the input
    send(1'b0, 8'd127, 28'h4000000, 28'h4000000, 1'b0, 1'b0, 32'd0, 32'h40000000, 1'b0, 4);
    sign = 1'b1; op_exp = 8'd127; mantis_great = 28'h4000000; mantis_small = 28'h0;
    eff_sub = 1'b0; special_in = 1'b0; special_result = 32'd0; in_valid = 1'b1;
    recv(5);
    send(1'b1, 8'd127, 28'h4000000, 28'h0, 1'b0, 1'b0, 32'd0, 32'hBF800000, 1'b0, 4);
    recv(0);

    // Reset in the middle of normalization discards the operation
    sign = 1'b0; op_exp = 8'd127; mantis_great = 28'h4000000;
    mantis_small = 28'h3FFFFF8; eff_sub = 1'b1; special_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_norm_state", {29'd0, dbg_state}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_state", {29'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("after_rst_no_output", {31'd0, seen}, 32'd0);

    // Random operations checked against the model
    for (int i = 0; i < 24; i++) begin
      sg  = 1'($urandom);
      e   = 8'($urandom_range(1, 254));
      g   = {2'b01, 26'($urandom)};
      s   = {2'b00, 26'($urandom)} >> $urandom_range(0, 27);
      sub = 1'($urandom);
      if (i % 6 == 0) s = g;
      model(sg, e, g, s, sub, mres, movf, mk);
      send(sg, e, g, s, sub, 1'b0, 32'd0, mres, movf, 4 + mk);
      recv($urandom_range(0, 2));
    end

    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
